mem_bus_unit: RTL and testbench
===============================

// Module: mem_bus_unit
// PURPOSE
//  Memory-side counterpart of the register unit: services instruction fetches ({CS,PC}) and
//  data loads/stores ({DS|SS,offset}, store data from V2) over an 8-bit external byte bus.
//  Returns 32-bit instruction words to the decoder and 16-bit load data (mem_data) to V2.
//  Sits between the CPU core and external memory; one transaction in flight at a time.
// PARAMETERS
//  MAX_WAIT  255  max cycles to wait for bus_ack per beat before abort; 0 disables timeout
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  fetch_req   in   1   level; request 4-byte instruction fetch
//  cs          in   8   code segment for fetch
//  pc          in   16  fetch offset
//  fetch_done  out  1   1-cycle pulse: fetch complete, instr valid
//  instr       out  32  fetched instruction {b3,b2,b1,b0}, b0 at lowest address
//  data_req    in   1   level; request data access
//  data_we     in   1   1=store, 0=load
//  data_byte   in   1   1=byte access, 0=16-bit word
//  seg         in   8   data segment (DS or SS, chosen by core)
//  addr        in   16  data offset
//  wdata       in   16  store data (V2)
//  data_done   out  1   1-cycle pulse: data access complete
//  rdata       out  16  load result (to mem_data)
//  bus_err     out  1   1-cycle pulse with *_done when transaction aborted on timeout
//  busy        out  1   high whenever state != IDLE
//  bus_addr    out  24  {segment, offset+beat}
//  bus_rd      out  1   read strobe, held across all beats of a read
//  bus_wr      out  1   write strobe, held across all beats of a write
//  bus_wdata   out  8   store byte for current beat
//  bus_rdata   in   8   read byte, sampled when bus_ack=1
//  bus_ack     in   1   beat complete
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (instr, rdata, bus_* included); strobes drop
//    immediately on rst even mid-transaction; partial data discarded, no done pulse.
//  - FSM: IDLE -> FETCH | DATA -> FIN -> IDLE. Requests sampled only in IDLE; req/addr/
//    seg/wdata/we/byte latched at acceptance; later input changes ignored until done.
//  - Arbitration: data_req and fetch_req both high in IDLE -> DATA wins; fetch waits.
//  - Beats: fetch 4, word 2, byte 1. Beat counter cnt from 0; bus_addr = {seg_l,
//    (off_l+cnt) mod 2^16} -- offset wraps, segment never increments.
//  - Beat completes in cycle where bus_ack=1; cnt advances, bus_addr updates next cycle.
//    Strobe stays high between beats; drops in FIN.
//  - Stores: bus_wdata = wdata_l[7:0] beat 0, wdata_l[15:8] beat 1 (little-endian).
//  - Loads: byte -> rdata = {8'h00,b0}; word -> rdata = {b1,b0}. rdata/instr update only
//    in FIN, held until next successful completion of the same kind.
//  - FIN: one cycle; pulse fetch_done or data_done; next request accepted the cycle after.
//  - Latency with zero-wait ack: req high at cycle 0 -> done pulse at cycle beats+1.
//  - Timeout: wait counter cleared each beat; reaches MAX_WAIT with no ack -> go to FIN,
//    strobes drop, done + bus_err pulse; rdata forced 16'hFFFF (load) / instr unchanged.
//    Ack in the same cycle the counter hits MAX_WAIT: ack wins, no error.
//  - bus_rd and bus_wr never both high; busy = (state != IDLE).
// TESTING
//  1 fetch cs=8'h12 pc=16'h0100, ack every cycle, bytes 11,22,33,44 -> addrs 120100..120103,
//    fetch_done at cycle 5, instr=32'h44332211.
//  2 word load seg=8'hFF addr=16'hFFFF, bytes AA,BB -> addrs FFFFFF then FF0000 (wrap),
//    rdata=16'hBBAA, data_done pulse.
//  3 byte store wdata=16'h1234 seg=8'h01 addr=16'h0010, ack after 3 waits -> one bus_wr beat
//    at 010010, bus_wdata=8'h34, done 1 cycle after ack.
//  4 fetch_req and data_req (word load) asserted same cycle -> data serviced first, fetch
//    starts cycle after data_done, both complete correctly.
//  5 MAX_WAIT=4, word load, ack never asserted -> abort after 4 wait cycles, data_done and
//    bus_err pulse together, rdata=16'hFFFF, bus_rd low; ack at wait 4 -> no error.
//  6 rst asserted mid-fetch after beat 1 -> strobes low same cycle, no done pulse, instr=0;
//    new fetch after rst release completes normally.

Source files
------------

// File: rtl/mem_bus_unit.sv
// Byte-wide memory bus sequencer: serves 4-byte instruction fetches and byte/word data loads and stores,
// with one transaction in flight at a time. A per-beat ack timeout aborts a transaction that stalls.
module mem_bus_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [7:0]  cs,
  input  logic [15:0] pc,
  output logic        fetch_done,
  output logic [31:0] instr,
  input  logic        data_req,
  input  logic        data_we,
  input  logic        data_byte,
  input  logic [7:0]  seg,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        data_done,
  output logic [15:0] rdata,
  output logic        bus_err,
  output logic        busy,
  output logic [23:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack
);

  // state | meaning
  // IDLE  | waiting for a request; data_req has priority over fetch_req
  // FETCH | four read beats of an instruction fetch
  // DATA  | one or two beats of a data load or store
  // FIN   | single cycle that carries the done pulse (and bus_err on abort)
  typedef enum logic [1:0] {IDLE, FETCH, DATA, FIN} state_t;

  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LOAD = WW'(MAX_WAIT);

  state_t        state;
  logic [7:0]    seg_l;
  logic [15:0]   off_l;
  logic [15:0]   wdata_l;
  logic          we_l;
  logic          byte_l;
  logic [1:0]    cnt;
  logic [1:0]    last;
  logic [23:0]   buf_q;
  logic [WW-1:0] wcnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      seg_l      <= '0;
      off_l      <= '0;
      wdata_l    <= '0;
      we_l       <= 1'b0;
      byte_l     <= 1'b0;
      cnt        <= '0;
      last       <= '0;
      buf_q      <= '0;
      wcnt       <= '0;
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
      bus_err    <= 1'b0;
      instr      <= '0;
      rdata      <= '0;
      bus_addr   <= '0;
      bus_rd     <= 1'b0;
      bus_wr     <= 1'b0;
      bus_wdata  <= '0;
    end else begin
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          wcnt <= WAIT_LOAD;
          if (data_req) begin
            seg_l     <= seg;
            off_l     <= addr;
            wdata_l   <= wdata;
            we_l      <= data_we;
            byte_l    <= data_byte;
            last      <= data_byte ? 2'd0 : 2'd1;
            bus_addr  <= {seg, addr};
            bus_rd    <= ~data_we;
            bus_wr    <= data_we;
            bus_wdata <= data_we ? wdata[7:0] : 8'h00;
            state     <= DATA;
          end else if (fetch_req) begin
            seg_l     <= cs;
            off_l     <= pc;
            we_l      <= 1'b0;
            byte_l    <= 1'b0;
            last      <= 2'd3;
            bus_addr  <= {cs, pc};
            bus_rd    <= 1'b1;
            bus_wdata <= 8'h00;
            state     <= FETCH;
          end
        end
        FETCH, DATA: begin
          if (bus_ack) begin
            if (cnt == last) begin
              state  <= FIN;
              bus_rd <= 1'b0;
              bus_wr <= 1'b0;
              if (state == FETCH) begin
                instr      <= {bus_rdata, buf_q};
                fetch_done <= 1'b1;
              end else begin
                data_done <= 1'b1;
                if (!we_l)
                  rdata <= byte_l ? {8'h00, bus_rdata} : {bus_rdata, buf_q[23:16]};
              end
            end else begin
              // Bytes shift in from the top so the earliest byte ends lowest.
              buf_q     <= {bus_rdata, buf_q[23:8]};
              cnt       <= cnt + 2'd1;
              bus_addr  <= {seg_l, off_l + {14'd0, cnt} + 16'd1};
              bus_wdata <= we_l ? wdata_l[15:8] : 8'h00;
              wcnt      <= WAIT_LOAD;
            end
          end else if ((MAX_WAIT != 0) && (wcnt == '0)) begin
            state   <= FIN;
            bus_rd  <= 1'b0;
            bus_wr  <= 1'b0;
            bus_err <= 1'b1;
            if (state == FETCH) begin
              fetch_done <= 1'b1;
            end else begin
              data_done <= 1'b1;
              if (!we_l)
                rdata <= 16'hFFFF;
            end
          end else if (wcnt != '0) begin
            wcnt <= wcnt - 1'b1;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed bench for mem_bus_unit: fetch, wrapping word load, waited byte store, arbitration,
// ack timeout with MAX_WAIT=4, and reset in the middle of a fetch.
module tb_mem_bus_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, data_req, data_we, data_byte, bus_ack;
  logic [7:0]  cs, seg, bus_rdata;
  logic [15:0] pc, addr, wdata;
  logic        fetch_done, data_done, bus_err, busy, bus_rd, bus_wr;
  logic [31:0] instr;
  logic [15:0] rdata;
  logic [23:0] bus_addr;
  logic [7:0]  bus_wdata;

  int vectors = 0;
  int errors  = 0;

  mem_bus_unit #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .cs(cs), .pc(pc), .fetch_done(fetch_done), .instr(instr),
    .data_req(data_req), .data_we(data_we), .data_byte(data_byte), .seg(seg), .addr(addr),
    .wdata(wdata), .data_done(data_done), .rdata(rdata), .bus_err(bus_err), .busy(busy),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_req = 0; data_req = 0; data_we = 0; data_byte = 0; bus_ack = 0;
    cs = 0; seg = 0; bus_rdata = 0; pc = 0; addr = 0; wdata = 0;
    step(); step();
    vectors++;
    if ({fetch_done, data_done, bus_err, busy, bus_rd, bus_wr} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {fetch_done, data_done, bus_err, busy, bus_rd, bus_wr});
    end
    vectors++;
    if ({instr, rdata, bus_addr, bus_wdata} !== 80'h0) begin
      errors++; $display("FAIL reset_data: instr=%h rdata=%h addr=%h wdata=%h want all 0", instr, rdata, bus_addr, bus_wdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    cs = 8'h12; pc = 16'h0100; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus_rd !== 1'b1 || bus_wr !== 1'b0 || bus_addr !== 24'h120100 + 24'(i)) begin
        errors++; $display("FAIL fetch_beat%0d: rd=%b wr=%b addr=%h want 1 0 %h", i, bus_rd, bus_wr, bus_addr, 24'h120100 + 24'(i));
      end
      bus_ack = 1'b1; bus_rdata = 8'h11 * 8'(i + 1);
      step();
    end
    bus_ack = 1'b0;
    vectors++;
    if (fetch_done !== 1'b1 || instr !== 32'h44332211 || bus_rd !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL fetch_done: done=%b instr=%h rd=%b err=%b want 1 44332211 0 0", fetch_done, instr, bus_rd, bus_err);
    end
    step();
    vectors++;
    if (fetch_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL fetch_after: done=%b busy=%b want 0 0", fetch_done, busy);
    end
  endtask

  task automatic test_word_load_wrap();
    seg = 8'hFF; addr = 16'hFFFF; data_we = 0; data_byte = 0; data_req = 1'b1;
    step();
    data_req = 1'b0;
    vectors++;
    if (bus_rd !== 1'b1 || bus_addr !== 24'hFFFFFF) begin
      errors++; $display("FAIL wrap_beat0: rd=%b addr=%h want 1 ffffff", bus_rd, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 8'hAA;
    step();
    vectors++;
    if (bus_rd !== 1'b1 || bus_addr !== 24'hFF0000 || data_done !== 1'b0) begin
      errors++; $display("FAIL wrap_beat1: rd=%b addr=%h done=%b want 1 ff0000 0", bus_rd, bus_addr, data_done);
    end
    bus_rdata = 8'hBB;
    step();
    bus_ack = 1'b0;
    vectors++;
    if (data_done !== 1'b1 || rdata !== 16'hBBAA || bus_err !== 1'b0 || bus_rd !== 1'b0) begin
      errors++; $display("FAIL wrap_done: done=%b rdata=%h err=%b rd=%b want 1 bbaa 0 0", data_done, rdata, bus_err, bus_rd);
    end
    step();
    vectors++;
    if (data_done !== 1'b0) begin
      errors++; $display("FAIL wrap_pulse: done=%b want 0", data_done);
    end
  endtask

  task automatic test_byte_store();
    seg = 8'h01; addr = 16'h0010; wdata = 16'h1234; data_we = 1; data_byte = 1; data_req = 1'b1;
    step();
    data_req = 1'b0; wdata = 16'hDEAD; seg = 8'h77;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus_wr !== 1'b1 || bus_rd !== 1'b0 || bus_addr !== 24'h010010 || bus_wdata !== 8'h34 || data_done !== 1'b0) begin
        errors++; $display("FAIL store_wait%0d: wr=%b rd=%b addr=%h wd=%h done=%b want 1 0 010010 34 0", i, bus_wr, bus_rd, bus_addr, bus_wdata, data_done);
      end
      bus_ack = (i == 3);
      step();
    end
    bus_ack = 1'b0;
    vectors++;
    if (data_done !== 1'b1 || bus_wr !== 1'b0 || bus_err !== 1'b0 || rdata !== 16'hBBAA) begin
      errors++; $display("FAIL store_done: done=%b wr=%b err=%b rdata=%h want 1 0 0 bbaa", data_done, bus_wr, bus_err, rdata);
    end
    step();
    data_we = 0; data_byte = 0;
  endtask

  task automatic test_back_to_back();
    bit seen;
    cs = 8'h20; pc = 16'h0000; seg = 8'h30; addr = 16'h0040; data_we = 0; data_byte = 0;
    fetch_req = 1'b1; data_req = 1'b1;
    step();
    data_req = 1'b0;
    vectors++;
    if (bus_rd !== 1'b1 || bus_addr !== 24'h300040) begin
      errors++; $display("FAIL arb_data_first: rd=%b addr=%h want 1 300040", bus_rd, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 8'h01;
    step();
    bus_rdata = 8'h02;
    step();
    bus_ack = 1'b0;
    vectors++;
    if (data_done !== 1'b1 || rdata !== 16'h0201 || fetch_done !== 1'b0) begin
      errors++; $display("FAIL arb_data_done: done=%b rdata=%h fdone=%b want 1 0201 0", data_done, rdata, fetch_done);
    end
    seen = 0;
    for (int k = 0; k < 4 && !seen; k++) begin
      step();
      if (bus_rd === 1'b1) seen = 1;
    end
    fetch_req = 1'b0;
    vectors++;
    if (!seen || bus_addr !== 24'h200000) begin
      errors++; $display("FAIL arb_fetch_start: started=%b addr=%h want 1 200000", seen, bus_addr);
    end
    for (int i = 0; i < 4; i++) begin
      bus_ack = 1'b1; bus_rdata = 8'hA0 + 8'(i);
      step();
    end
    bus_ack = 1'b0;
    vectors++;
    if (fetch_done !== 1'b1 || instr !== 32'hA3A2A1A0 || rdata !== 16'h0201) begin
      errors++; $display("FAIL arb_fetch_done: done=%b instr=%h rdata=%h want 1 a3a2a1a0 0201", fetch_done, instr, rdata);
    end
    step();
  endtask

  task automatic test_timeout();
    seg = 8'h05; addr = 16'h0000; data_we = 0; data_byte = 0; data_req = 1'b1;
    step();
    data_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus_rd !== 1'b1 || data_done !== 1'b0 || bus_err !== 1'b0) begin
        errors++; $display("FAIL timeout_wait%0d: rd=%b done=%b err=%b want 1 0 0", i, bus_rd, data_done, bus_err);
      end
      step();
    end
    vectors++;
    if (data_done !== 1'b1 || bus_err !== 1'b1 || rdata !== 16'hFFFF || bus_rd !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: done=%b err=%b rdata=%h rd=%b want 1 1 ffff 0", data_done, bus_err, rdata, bus_rd);
    end
    step();
    vectors++;
    if (bus_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_after: err=%b busy=%b want 0 0", bus_err, busy);
    end
    addr = 16'h0010; data_req = 1'b1;
    step();
    data_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus_ack = 1'b1; bus_rdata = 8'h5A;
    step();
    vectors++;
    if (bus_rd !== 1'b1 || bus_addr !== 24'h050011 || bus_err !== 1'b0 || data_done !== 1'b0) begin
      errors++; $display("FAIL ack_at_limit: rd=%b addr=%h err=%b done=%b want 1 050011 0 0", bus_rd, bus_addr, bus_err, data_done);
    end
    bus_rdata = 8'hC3;
    step();
    bus_ack = 1'b0;
    vectors++;
    if (data_done !== 1'b1 || bus_err !== 1'b0 || rdata !== 16'hC35A) begin
      errors++; $display("FAIL ack_at_limit_done: done=%b err=%b rdata=%h want 1 0 c35a", data_done, bus_err, rdata);
    end
    step();
  endtask

  task automatic test_reset_mid_fetch();
    bit pulse;
    cs = 8'h40; pc = 16'h0000; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    bus_ack = 1'b1; bus_rdata = 8'h99;
    step(); step();
    bus_ack = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus_rd !== 1'b0 || busy !== 1'b0 || instr !== 32'h0 || rdata !== 16'h0 || bus_addr !== 24'h0) begin
      errors++; $display("FAIL rst_mid: rd=%b busy=%b instr=%h rdata=%h addr=%h want 0 0 0 0 0", bus_rd, busy, instr, rdata, bus_addr);
    end
    pulse = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (fetch_done || data_done) pulse = 1;
    end
    rst = 1'b0;
    step();
    if (fetch_done || data_done) pulse = 1;
    vectors++;
    if (pulse !== 1'b0) begin
      errors++; $display("FAIL rst_no_done: pulse=%b want 0", pulse);
    end
    cs = 8'h41; pc = 16'h0010; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    vectors++;
    if (bus_rd !== 1'b1 || bus_addr !== 24'h410010) begin
      errors++; $display("FAIL rst_refetch_start: rd=%b addr=%h want 1 410010", bus_rd, bus_addr);
    end
    for (int i = 0; i < 4; i++) begin
      bus_ack = 1'b1; bus_rdata = 8'h0F + 8'(i);
      step();
    end
    bus_ack = 1'b0;
    vectors++;
    if (fetch_done !== 1'b1 || instr !== 32'h1211100F || bus_err !== 1'b0) begin
      errors++; $display("FAIL rst_refetch_done: done=%b instr=%h err=%b want 1 1211100f 0", fetch_done, instr, bus_err);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_word_load_wrap();
    test_byte_store();
    test_back_to_back();
    test_timeout();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
